serial_multiplier: RTL and testbench

- Runtime, sequential counterpart to the team's constant-function arithmetic: computes an unsigned product in hardware over several cycles.
- Operands must be known only at run time.
- Radix-2 shift-add multiplier with valid/ready handshakes on both operand and result sides.
- Instantiated in datapaths where multiply throughput is low and area matters, e.g. address and length scaling in DMA and packet engines.

---
 rtl/serial_multiplier.sv | 100 ++++++++++
 tb/tb_serial_multiplier.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_multiplier.sv
// Radix-2 shift-add unsigned multiplier: one partial product per clock, WIDTH
// iterations per operand pair, valid/ready handshakes on both sides.
module serial_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clear_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [WIDTH-1:0]   op_a_i,
   input  logic [WIDTH-1:0]   op_b_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [2*WIDTH-1:0] product_o,
   output logic               busy_o
);

   // Iteration counter width, ceil(log2(WIDTH)), derived from WIDTH.
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q,   cnt_d;
   logic [2*WIDTH-1:0]   a_q,     a_d;
   logic [2*WIDTH-1:0]   acc_q,   acc_d;
   logic [WIDTH-1:0]     b_q,     b_d;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid_i && !clear_i) begin
               a_d     = {{WIDTH{1'b0}}, op_a_i};
               b_d     = op_b_i;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (b_q[0]) begin
               acc_d = acc_q + a_q;
            end
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort wins over any handshake in the same cycle.
      if (clear_i) begin
         state_d = IDLE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
      end
   end

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign busy_o      = (state_q != IDLE);
   assign product_o   = acc_q;

endmodule

// File: tb/tb_serial_multiplier.sv
// Directed and random checks of serial_multiplier at WIDTH=8 and WIDTH=32:
// latency, handshakes, stall hold, clear abort and asynchronous reset.
module tb_serial_multiplier;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // WIDTH=8 instance
   logic        clr8 = 1'b0, iv8 = 1'b0, ir8, ov8, or8 = 1'b0, busy8;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [15:0] p8;

   // WIDTH=32 instance
   logic        clr32 = 1'b0, iv32 = 1'b0, ir32, ov32, or32 = 1'b0, busy32;
   logic [31:0] a32 = '0, b32 = '0;
   logic [63:0] p32;

   serial_multiplier #(.WIDTH(8)) u_dut8 (
      .clk_i(clk), .rst_i(rst), .clear_i(clr8),
      .in_valid_i(iv8), .in_ready_o(ir8), .op_a_i(a8), .op_b_i(b8),
      .out_valid_o(ov8), .out_ready_i(or8), .product_o(p8), .busy_o(busy8)
   );

   serial_multiplier #(.WIDTH(32)) u_dut32 (
      .clk_i(clk), .rst_i(rst), .clear_i(clr32),
      .in_valid_i(iv32), .in_ready_o(ir32), .op_a_i(a32), .op_b_i(b32),
      .out_valid_o(ov32), .out_ready_i(or32), .product_o(p32), .busy_o(busy32)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full WIDTH=8 transaction from IDLE; checks latency, busy and product.
   task automatic mul8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp);
      int  k;
      logic busy_ok;
      iv8 = 1'b1; a8 = a; b8 = b; or8 = 1'b0;
      tick();
      iv8 = 1'b0; a8 = ~a; b8 = ~b;   // later operand changes must be ignored
      k = 0;
      busy_ok = 1'b1;
      while (!ov8 && k < 20) begin
         if (!busy8 || ir8) busy_ok = 1'b0;
         tick();
         k++;
      end
      check({tag, "_latency"}, 64'(k), 64'd8);
      check({tag, "_busy"}, {63'd0, busy_ok && busy8 && !ir8}, 64'd1);
      check({tag, "_product"}, 64'(p8), 64'(exp));
      or8 = 1'b1;
      tick();
      or8 = 1'b0;
      check({tag, "_idle"}, {62'd0, ir8, busy8}, 64'b10);
   endtask

   initial begin
      int   k, acc_n, res_n, last;
      logic seen;
      logic [7:0]  ra, rb;
      logic [15:0] expq[$];
      logic [15:0] e;

      // Reset state
      #1;
      check("rst8_outputs",  {60'd0, ir8, ov8, busy8, 1'b0}, 64'b1000);
      check("rst8_product",  64'(p8), 64'd0);
      check("rst32_outputs", {60'd0, ir32, ov32, busy32, 1'b0}, 64'b1000);
      check("rst32_product", p32, 64'd0);
      tick();
      rst = 1'b0;
      tick();

      // Directed WIDTH=8 products
      mul8("m13x11",  8'd13,  8'd11,  16'd143);
      mul8("m255sq",  8'd255, 8'd255, 16'd65025);
      mul8("m0x200",  8'd0,   8'd200, 16'd0);
      mul8("m200x0",  8'd200, 8'd0,   16'd0);

      // WIDTH=32 all-ones with a 5-cycle output stall
      iv32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; or32 = 1'b0;
      tick();
      iv32 = 1'b0; a32 = '0; b32 = '0;
      k = 0;
      while (!ov32 && k < 40) begin
         tick();
         k++;
      end
      check("w32_latency", 64'(k), 64'd32);
      check("w32_product", p32, 64'hFFFF_FFFE_0000_0001);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("w32_stall_valid", {62'd0, ov32, ir32}, 64'b10);
         check("w32_stall_product", p32, 64'hFFFF_FFFE_0000_0001);
      end
      or32 = 1'b1;
      tick();
      or32 = 1'b0;
      check("w32_released", {62'd0, ir32, ov32}, 64'b10);

      // Back-to-back random stream, both sides always ready
      acc_n = 0; res_n = 0; last = -1;
      or8 = 1'b1;
      for (int cyc = 0; cyc < 10300 && res_n < 1000; cyc++) begin
         iv8 = (acc_n < 1000);
         if (ir8 && iv8) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            a8 = ra; b8 = rb;
            e  = 16'(ra) * 16'(rb);
            expq.push_back(e);
            if (last >= 0) check("b2b_interval", 64'(cyc - last), 64'd10);
            last = cyc;
            acc_n++;
         end
         if (ov8) begin
            if (expq.size() == 0) begin
               check("b2b_unexpected_result", 64'(p8), 64'hDEAD);
            end else begin
               e = expq.pop_front();
               check("b2b_product", 64'(p8), 64'(e));
            end
            res_n++;
         end
         tick();
      end
      iv8 = 1'b0; or8 = 1'b0;
      check("b2b_result_count", 64'(res_n), 64'd1000);
      tick();

      // clear_i on the 4th BUSY cycle aborts the operation
      iv8 = 1'b1; a8 = 8'd100; b8 = 8'd100;
      tick();
      iv8 = 1'b0;
      tick(); tick(); tick();
      clr8 = 1'b1;
      tick();
      clr8 = 1'b0;
      check("clr_idle", {62'd0, ir8, busy8}, 64'b10);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (ov8) seen = 1'b1;
         tick();
      end
      check("clr_no_valid", {63'd0, seen}, 64'd0);
      mul8("m7x9", 8'd7, 8'd9, 16'd63);

      // clear_i with in_valid_i in IDLE blocks acceptance
      clr8 = 1'b1; iv8 = 1'b1; a8 = 8'd2; b8 = 8'd3;
      tick();
      clr8 = 1'b0; iv8 = 1'b0;
      check("clr_blocks_accept", {62'd0, ir8, busy8}, 64'b10);
      tick();
      check("clr_still_idle", {62'd0, ir8, busy8}, 64'b10);

      // Asynchronous reset mid-BUSY
      iv8 = 1'b1; a8 = 8'd200; b8 = 8'd3;
      tick();
      iv8 = 1'b0;
      tick(); tick(); tick();
      #2;
      rst = 1'b1;
      #1;
      check("arst_outputs", {60'd0, ir8, ov8, busy8, 1'b0}, 64'b1000);
      check("arst_product", 64'(p8), 64'd0);
      check("arst_product32", p32, 64'd0);
      tick();
      #2;
      rst = 1'b0;
      tick();
      mul8("m3x5", 8'd3, 8'd5, 16'd15);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
